// File: rtl/data_bus_bridge_pkg.sv
// Shared definitions for the MEM-stage data bus bridge: FSM encoding,
// default transaction timeout and the all-zero data word.
package data_bus_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_DROP = 3'd4
    } state_t;

    localparam int          TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] ZeroWord        = 32'h0000_0000;

endpackage

// File: rtl/data_bus_bridge.sv
// Bridges MEM-stage loads/stores onto a req/gnt/rvalid bus; stalls the pipe for
// 2+ cycles (IDLE->REQ->DONE minimum), holds bus_* stable until granted, times out after TIMEOUT cycles.
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
);

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       stall, issue, drop_req, take_data, timeout, expired;

    // >= rather than == so a grant on the final REQ cycle still times out in WAIT.
    assign expired    = (cnt >= 8'(TIMEOUT - 1));
    assign stallreq_o = stall & ~rst;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        issue     = 1'b0;
        drop_req  = 1'b0;
        take_data = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    stall     = 1'b1;
                    issue     = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (flush_i) begin
                    drop_req  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (bus_gnt_i) begin
                    drop_req  = 1'b1;
                    take_data = bus_rvalid_i;
                    state_nxt = bus_rvalid_i ? S_DONE : S_WAIT;
                end else if (expired) begin
                    drop_req  = 1'b1;
                    timeout   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                // A response coinciding with a flush drains the request but is discarded.
                if (bus_rvalid_i) begin
                    take_data = !flush_i;
                    state_nxt = flush_i ? S_IDLE : S_DONE;
                end else if (expired) begin
                    timeout   = 1'b1;
                    state_nxt = S_DONE;
                end else if (flush_i) begin
                    state_nxt = S_DROP;
                end
            end
            S_DONE: begin
                if (flush_i || !stall_i) state_nxt = S_IDLE;
            end
            S_DROP: begin
                stall = cpu_ce_i;
                if (bus_rvalid_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'h0;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
            cpu_data_o  <= ZeroWord;
            bus_err_o   <= 1'b0;
            cnt         <= 8'h0;
        end else begin
            bus_err_o <= timeout;
            if (issue) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= cpu_we_i;
                bus_sel_o   <= cpu_sel_i;
                bus_addr_o  <= cpu_addr_i;
                bus_wdata_o <= cpu_data_i;
                cnt         <= 8'h0;
            end else if (state == S_REQ || state == S_WAIT) begin
                cnt <= cnt + 8'd1;
            end
            if (drop_req) bus_req_o <= 1'b0;
            if (take_data && !bus_we_o) cpu_data_o <= bus_rdata_i;
            if (timeout) cpu_data_o <= ZeroWord;
        end
    end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Self-checking bench for data_bus_bridge: directed table, flush/timeout/reset
// sequences and randomized transactions scored against a transaction-level model.
module tb_data_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i, cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic        stallreq_o, stall_i, flush_i;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_data;
    int          first_err, errs, k;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          g;          // REQ cycle carrying gnt (1 = first)
        int          r;          // cycles from gnt to rvalid (0 = same cycle)
        int          h;          // cycles stall_i held in DONE
        int          gap;        // idle cycles before the access
        int          exp_stall;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[5];
    vec_t rv;

    data_bus_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_ce_i     (cpu_ce_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_sel_i    (cpu_sel_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .stallreq_o   (stallreq_o),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_sel_o    (bus_sel_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_ce_i     = 1'b0;
        cpu_we_i     = 1'b0;
        cpu_sel_i    = 4'h0;
        cpu_addr_i   = 32'h0;
        cpu_data_i   = 32'h0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = $urandom;
    endtask

    // One complete access: optional idle gap with stray responses, the stalled
    // request/response phase, then DONE held for h cycles by stall_i.
    task automatic run_txn(input string tag, input vec_t v);
        int stalls = 0;
        int reqs   = 0;
        bit bus_ok = 1'b1;
        bit gap_ok = 1'b1;
        for (int i = 0; i < v.gap; i++) begin
            idle_inputs();
            bus_rvalid_i = 1'b1;
            @(negedge clk);
            if (stallreq_o || bus_req_o) gap_ok = 1'b0;
            next_cycle();
        end
        for (int c = 0; c <= v.g + v.r; c++) begin
            idle_inputs();
            cpu_ce_i = 1'b1;
            if (c == 0) begin
                cpu_we_i   = v.we;
                cpu_sel_i  = v.sel;
                cpu_addr_i = v.addr;
                cpu_data_i = v.data;
            end else begin
                cpu_we_i   = 1'($urandom);
                cpu_sel_i  = 4'($urandom);
                cpu_addr_i = $urandom;
                cpu_data_i = $urandom;
            end
            bus_gnt_i    = (c == v.g);
            bus_rvalid_i = (c == v.g + v.r);
            if (bus_rvalid_i) bus_rdata_i = v.rdata;
            @(negedge clk);
            if (stallreq_o) stalls++;
            if (bus_req_o) reqs++;
            if (c >= 1 && c <= v.g &&
                {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== {v.we, v.sel, v.addr, v.data})
                bus_ok = 1'b0;
            next_cycle();
        end
        for (int j = 0; j <= v.h; j++) begin
            idle_inputs();
            cpu_ce_i     = 1'b1;
            stall_i      = (j < v.h);
            bus_rvalid_i = 1'($urandom);
            @(negedge clk);
            if (stallreq_o) stalls++;
            if (bus_req_o) reqs++;
            if (j == v.h) chk($sformatf("%s cpu_data", tag), cpu_data_o, v.exp_data);
            next_cycle();
        end
        chk($sformatf("%s stall_cycles", tag), 32'(stalls), 32'(v.exp_stall));
        chk($sformatf("%s req_cycles", tag), 32'(reqs), 32'(v.g));
        chk($sformatf("%s bus_stable", tag), 32'(bus_ok), 32'd1);
        chk($sformatf("%s idle_quiet", tag), 32'(gap_ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        // Reset with an access pending on the inputs: nothing may leak out.
        idle_inputs();
        rst          = 1'b1;
        cpu_ce_i     = 1'b1;
        cpu_addr_i   = 32'h1234_0000;
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset stallreq", 32'(stallreq_o), 32'd0);
        chk("reset ctl", 32'({bus_req_o, bus_we_o, bus_sel_o, bus_err_o}), 32'd0);
        chk("reset addr", bus_addr_o, 32'd0);
        chk("reset cpu_data", cpu_data_o, 32'd0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        next_cycle();

        //           we    sel    addr          data          rdata         g  r  h  gap stall exp_data
        tbl[0] = '{1'b0, 4'hF, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 1, 0, 0, 1,  2, 32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 4'h3, 32'h0000_0200, 32'h1234_5678, 32'h5A5A_5A5A, 3, 2, 0, 0,  6, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 4'hF, 32'h0000_0108, 32'h0,        32'hCAFE_F00D, 1, 1, 4, 0,  3, 32'hCAFE_F00D};
        tbl[3] = '{1'b0, 4'h1, 32'h0000_010C, 32'h0,        32'h0000_00A5, 2, 0, 0, 2,  3, 32'h0000_00A5};
        tbl[4] = '{1'b1, 4'hC, 32'h0000_0110, 32'h8765_4321, 32'hFFFF_0000, 1, 0, 1, 0,  2, 32'h0000_00A5};
        for (int i = 0; i < 5; i++) run_txn($sformatf("vec%0d", i), tbl[i]);
        model_data = 32'h0000_00A5;

        // Flush in REQ wins over a same-cycle grant.
        idle_inputs(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0700;
        next_cycle();
        cpu_ce_i = 1'b1; flush_i = 1'b1; bus_gnt_i = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("flush_req bus_req", 32'(bus_req_o), 32'd0);
        chk("flush_req stallreq", 32'(stallreq_o), 32'd0);
        next_cycle();

        // Flush in WAIT: response dropped, new access waits for DROP to end.
        idle_inputs(); cpu_ce_i = 1'b1; cpu_sel_i = 4'hF; cpu_addr_i = 32'h0000_0300;
        next_cycle();
        bus_gnt_i = 1'b1;
        next_cycle();
        bus_gnt_i = 1'b0; flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0; cpu_addr_i = 32'h0000_0400;
        for (int i = 0; i < 3; i++) begin
            bus_rvalid_i = (i == 2);
            bus_rdata_i  = (i == 2) ? 32'hAAAA_5555 : $urandom;
            @(negedge clk);
            chk($sformatf("drop%0d stallreq", i), 32'(stallreq_o), 32'd1);
            chk($sformatf("drop%0d bus_req", i), 32'(bus_req_o), 32'd0);
            next_cycle();
        end
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        chk("after_drop bus_req", 32'(bus_req_o), 32'd0);
        chk("after_drop cpu_data", cpu_data_o, model_data);
        next_cycle();
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h3C3C_0F0F;
        @(negedge clk);
        chk("reissue bus_req", 32'(bus_req_o), 32'd1);
        chk("reissue bus_addr", bus_addr_o, 32'h0000_0400);
        next_cycle();
        idle_inputs(); cpu_ce_i = 1'b1;
        @(negedge clk);
        chk("reissue cpu_data", cpu_data_o, 32'h3C3C_0F0F);
        next_cycle();
        model_data = 32'h3C3C_0F0F;

        // Grant never arrives: error pulse after TIMEOUT cycles in REQ.
        idle_inputs(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0500;
        first_err = -1; errs = 0; k = 0;
        while (k < 400) begin
            @(negedge clk);
            if (bus_err_o) begin
                errs++;
                if (first_err < 0) first_err = k;
            end
            if (k > 0 && !stallreq_o) break;
            next_cycle();
            k++;
        end
        chk("timeout done_cycle", 32'(k), 32'd256);
        chk("timeout cpu_data", cpu_data_o, 32'd0);
        chk("timeout bus_req", 32'(bus_req_o), 32'd0);
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_err_o) errs++;
            next_cycle();
        end
        chk("timeout err_pulses", 32'(errs), 32'd1);
        chk("timeout err_cycle", 32'(first_err), 32'd256);
        model_data = 32'd0;

        // Randomized accesses against the transaction-level model.
        for (int t = 0; t < 40; t++) begin
            rv.we    = 1'($urandom);
            rv.sel   = 4'($urandom);
            rv.addr  = $urandom;
            rv.data  = $urandom;
            rv.rdata = $urandom;
            rv.g     = int'($urandom_range(1, 6));
            rv.r     = int'($urandom_range(0, 4));
            rv.h     = int'($urandom_range(0, 3));
            rv.gap   = int'($urandom_range(0, 2));
            rv.exp_stall = 1 + rv.g + rv.r;
            if (!rv.we) model_data = rv.rdata;
            rv.exp_data = model_data;
            run_txn($sformatf("rnd%0d", t), rv);
        end

        // Reset while waiting on a write response.
        idle_inputs(); cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_sel_i = 4'hF;
        cpu_addr_i = 32'h0000_0600; cpu_data_i = 32'hFACE_B00C;
        next_cycle();
        bus_gnt_i = 1'b1;
        next_cycle();
        bus_gnt_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_wait stallreq", 32'(stallreq_o), 32'd0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rst_wait ctl", 32'({bus_req_o, bus_we_o, bus_sel_o, bus_err_o, stallreq_o}), 32'd0);
        chk("rst_wait addr", bus_addr_o, 32'd0);
        chk("rst_wait wdata", bus_wdata_o, 32'd0);
        chk("rst_wait cpu_data", cpu_data_o, 32'd0);
        next_cycle();
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("rst_late_rvalid cpu_data", cpu_data_o, 32'd0);
        next_cycle();
        rv = '{1'b0, 4'hF, 32'h0000_0800, 32'h0, 32'h0BAD_F00D, 1, 0, 0, 0, 2, 32'h0BAD_F00D};
        run_txn("post_rst", rv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
